// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if: producer, register-file write and forwarding signals of the writeback queue
interface regfile_writeback_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W = 3
);
  logic alu_valid, alu_ready, mem_valid, mem_ready, wb_hold;
  logic write_enable, fwd1_hit, fwd2_hit, empty;
  logic [ADDR_W-1:0] alu_rd, mem_rd, write_reg_addr, fwd1_addr, fwd2_addr;
  logic [DATA_W-1:0] alu_data, mem_data, write_data, fwd1_data, fwd2_data;
  logic [CNT_W-1:0] count;
  modport master(
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_hold, fwd1_addr, fwd2_addr,
    input alu_ready, mem_ready, write_enable, write_reg_addr, write_data, fwd1_hit, fwd1_data,
    fwd2_hit, fwd2_data, count, empty
  );
  modport slave(
    input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_hold, fwd1_addr, fwd2_addr,
    output alu_ready, mem_ready, write_enable, write_reg_addr, write_data, fwd1_hit, fwd1_data,
    fwd2_hit, fwd2_data, count, empty
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order writeback FIFO draining ALU/load results into the register file with forwarding
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  regfile_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic not_full, push, pop;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  assign not_full = cnt != CW'(DEPTH);
  assign bus.mem_ready = reset & not_full;
  assign bus.alu_ready = reset & not_full & ~bus.mem_valid;
  assign in_rd = bus.mem_valid ? bus.mem_rd : bus.alu_rd;
  assign in_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
  assign push = ((bus.mem_valid & bus.mem_ready) | (bus.alu_valid & bus.alu_ready)) & (in_rd != '0);
  assign pop = reset & (cnt != '0) & ~bus.wb_hold;
  assign bus.write_enable = pop;
  assign bus.write_reg_addr = rd_q[rp];
  assign bus.write_data = data_q[rp];
  assign bus.count = cnt;
  assign bus.empty = cnt == '0;
  // Pointer, occupancy and entry-valid bookkeeping; x0 writes never reach here as a push
  always_ff @(posedge clk) begin
    if (!reset) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (push) vld[wp] <= 1'b1;
      if (pop) vld[rp] <= 1'b0;
      wp <= push ? wp + PW'(1) : wp;
      rp <= pop ? rp + PW'(1) : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // Entry payload storage; contents are irrelevant until the valid bit is set
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wp] <= in_rd;
      data_q[wp] <= in_data;
    end
  end
  // Forwarding: scan oldest to youngest so the entry nearest the tail wins
  always_comb begin
    bus.fwd1_hit = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit = 1'b0;
    bus.fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[rp + PW'(i)] && bus.fwd1_addr != '0 && rd_q[rp + PW'(i)] == bus.fwd1_addr) begin
        bus.fwd1_hit = 1'b1;
        bus.fwd1_data = data_q[rp + PW'(i)];
      end
      if (vld[rp + PW'(i)] && bus.fwd2_addr != '0 && rd_q[rp + PW'(i)] == bus.fwd2_addr) begin
        bus.fwd2_hit = 1'b1;
        bus.fwd2_data = data_q[rp + PW'(i)];
      end
    end
  end
endmodule
